// File: rtl/decode_issue_queue.sv
// Decode/issue queue: DEPTH-entry instruction FIFO with head register-usage decode
// and a pending-destination scoreboard. Optional macro: DECODE_WB_BYPASS_EN.
module decode_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_rd_we,
    output logic             out_illegal,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] occupancy,
    output logic [31:0]      pending
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      pending_q, pending_nxt, eff_pending;
    logic             full, empty, push, pop, hazard;
    logic             uses_rs1, uses_rs2, uses_rd;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    // reset gates in_ready so it reads 0 while the block is held in reset
    assign in_ready  = reset && !full && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count_q;
    assign pending   = pending_q;

    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];
    assign out_rs1   = out_instr[19:15];
    assign out_rs2   = out_instr[24:20];
    assign out_rd    = out_instr[11:7];

    // Head opcode decode into register usage
    always_comb begin
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        uses_rd     = 1'b0;
        out_illegal = 1'b0;
        case (out_instr[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: uses_rd = 1'b1;
            7'b1100111, 7'b0000011, 7'b0010011: begin
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
            end
            7'b1100011, 7'b0100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0110011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                uses_rd  = 1'b1;
            end
            7'b0001111: ;
            7'b1110011: begin
                uses_rs1 = (out_instr[14:12] != 3'b000);
                uses_rd  = (out_instr[14:12] != 3'b000);
            end
            default: out_illegal = 1'b1;
        endcase
    end

    assign out_rd_we = uses_rd && (out_rd != 5'd0);

`ifdef DECODE_WB_BYPASS_EN
    assign eff_pending = pending_q & ~(wb_valid ? (32'(1) << wb_rd) : 32'd0);
`else
    assign eff_pending = pending_q;
`endif

    assign hazard    = (uses_rs1 && eff_pending[out_rs1]) ||
                       (uses_rs2 && eff_pending[out_rs2]) ||
                       (out_rd_we && eff_pending[out_rd]);
    assign out_valid = !empty && !hazard && !flush;

    // Scoreboard: write-back clears, issue sets; set applied last so it wins
    always_comb begin
        pending_nxt = pending_q;
        if (wb_valid)
            pending_nxt[wb_rd] = 1'b0;
        if (pop && out_rd_we)
            pending_nxt[out_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)
                    count_q <= count_q + CNT_W'(1);
                else if (!push && pop)
                    count_q <= count_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed self-checking bench for decode_issue_queue (honours DECODE_WB_BYPASS_EN).
module tb_decode_issue_queue;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rd_we, out_illegal;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [2:0]  occupancy;
    logic [31:0] pending;

    int tests = 0;
    int failed = 0;
`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    decode_issue_queue #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .occupancy(occupancy), .pending(pending)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] addi(input logic [4:0] rd);
        return 32'h0000_0013 | (32'(rd) << 7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push1(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] pc_hold;

    initial begin
        // reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_pend", pending, 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_ir", 32'(in_ready), 32'd1);

        // fill with ADDI x1..x4, out_ready low
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_instr = addi(5'(i));
            in_pc    = 32'h100 + 32'(4 * (i - 1));
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("fill_occ", 32'(occupancy), 32'd4);
        chk("fill_ir", 32'(in_ready), 32'd0);
        chk("fill_head_rd", 32'(out_rd), 32'd1);

        // drain in FIFO order
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_ov", 32'(out_valid), 32'd1);
            chk("drain_rd", 32'(out_rd), 32'(i));
            chk("drain_pc", out_pc, 32'h100 + 32'(4 * (i - 1)));
            tick();
        end
        out_ready = 1'b0;
        #1;
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_pend", pending, 32'h0000_001E);

        // RAW: ADD x5,x1,x2 with x1,x2 pending
        push1(32'h0020_82B3, 32'h200);
        wb_valid = 1'b1;
        wb_rd    = 5'd2;
        #1;
        chk("raw_stall", 32'(out_valid), 32'd0);
        tick();
        wb_rd = 5'd1;
        #1;
        chk("raw_wb_cycle", 32'(out_valid), BYP ? 32'd1 : 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("raw_after_wb", 32'(out_valid), 32'd1);
        chk("raw_rs1", 32'(out_rs1), 32'd1);
        chk("raw_rs2", 32'(out_rs2), 32'd2);
        chk("raw_pend", pending, 32'h0000_0018);
        pc_hold = out_pc;
        tick();
        chk("hold_pc", out_pc, pc_hold);
        chk("hold_ov", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("raw_set_x5", pending, 32'h0000_0038);
        chk("raw_occ", 32'(occupancy), 32'd0);

        // LUI x0 and an illegal all-zero word
        push1(32'h1234_5037, 32'h300);
        #1;
        chk("lui0_ov", 32'(out_valid), 32'd1);
        chk("lui0_we", 32'(out_rd_we), 32'd0);
        chk("lui0_ill", 32'(out_illegal), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("lui0_pend", pending, 32'h0000_0038);
        push1(32'h0000_0000, 32'h304);
        #1;
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_ov", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("ill_pend", pending, 32'h0000_0038);
        chk("ill_occ", 32'(occupancy), 32'd0);

        // fill, then flush with in_valid and out_ready asserted
        for (int i = 6; i <= 9; i++) push1(addi(5'(i)), 32'h400 + 32'(i));
        #1;
        chk("fl_full", 32'(occupancy), 32'd4);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = addi(5'd10);
        out_ready = 1'b1;
        #1;
        chk("fl_ov", 32'(out_valid), 32'd0);
        chk("fl_ir", 32'(in_ready), 32'd0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_pend", pending, 32'h0000_0038);

        // clear x3, then pop ADDI x3 in the same cycle as a write-back to x3
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("x3_clr", pending, 32'h0000_0030);
        push1(addi(5'd3), 32'h500);
        wb_valid  = 1'b1;
        wb_rd     = 5'd3;
        out_ready = 1'b1;
        #1;
        chk("x3_issue", 32'(out_valid), 32'd1);
        tick();
        wb_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("x3_set_wins", pending, 32'h0000_0038);

        // SW x3 stalls until the next write-back to x3
        push1(32'h0030_2023, 32'h504);
        #1;
        chk("sw_stall0", 32'(out_valid), 32'd0);
        tick();
        chk("sw_stall1", 32'(out_valid), 32'd0);
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        #1;
        chk("sw_wb_cycle", 32'(out_valid), BYP ? 32'd1 : 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("sw_issue", 32'(out_valid), 32'd1);
        chk("sw_rs2", 32'(out_rs2), 32'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("sw_pend", pending, 32'h0000_0030);
        chk("sw_occ", 32'(occupancy), 32'd0);

        // asynchronous reset with three entries queued
        for (int i = 10; i <= 12; i++) push1(addi(5'(i)), 32'h600 + 32'(i));
        #1;
        chk("ar_occ_pre", 32'(occupancy), 32'd3);
        chk("ar_ov_pre", 32'(out_valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("ar_occ", 32'(occupancy), 32'd0);
        chk("ar_pend", pending, 32'd0);
        chk("ar_ov", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
